// File: rtl/mem_arbiter_if.sv
// Channel bundle for mem_arbiter: IFU request/response, LSU request/response and the shared memory port.
// slave is the arbiter's view; master is the view of the surrounding core and memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic                  ifu_valid;
   logic                  ifu_ready;
   logic [ADDR_W-1:0]     ifu_addr;
   logic                  ifu_rvalid;
   logic                  ifu_rready;
   logic [DATA_W-1:0]     ifu_rdata;

   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [ADDR_W-1:0]     lsu_addr;
   logic                  lsu_wen;
   logic [DATA_W-1:0]     lsu_wdata;
   logic [DATA_W/8-1:0]   lsu_wmask;
   logic                  lsu_rvalid;
   logic                  lsu_rready;
   logic [DATA_W-1:0]     lsu_rdata;

   logic                  mem_valid;
   logic                  mem_ready;
   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_wen;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wmask;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  ifu_valid, ifu_addr, ifu_rready,
      input  lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rready,
      input  mem_ready, mem_rvalid, mem_rdata,
      output ifu_ready, ifu_rvalid, ifu_rdata,
      output lsu_ready, lsu_rvalid, lsu_rdata,
      output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );

   modport master (
      output ifu_valid, ifu_addr, ifu_rready,
      output lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rready,
      output mem_ready, mem_rvalid, mem_rdata,
      input  ifu_ready, ifu_rvalid, ifu_rdata,
      input  lsu_ready, lsu_rvalid, lsu_rdata,
      input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU reads and LSU reads/writes,
// one transaction outstanding, sequenced through IDLE -> REQ -> WAIT -> RESP.
module mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                r_last_lsu;
   logic                r_owner_lsu;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wen;
   logic [DATA_W-1:0]   r_wdata;
   logic [MASK_W-1:0]   r_wmask;
   logic [DATA_W-1:0]   r_rdata;
   logic                w_grant_ifu;
   logic                w_grant_lsu;
   logic                w_accept;
   logic                w_owner_rready;
   logic                w_ifu_rvalid;
   logic                w_lsu_rvalid;

   // A lone requester wins; on conflict the side that was not granted last time wins.
   always_comb begin
      w_grant_ifu = 1'b0;
      w_grant_lsu = 1'b0;
      if (bus.ifu_valid && bus.lsu_valid) begin
         w_grant_ifu = r_last_lsu;
         w_grant_lsu = ~r_last_lsu;
      end else begin
         w_grant_ifu = bus.ifu_valid;
         w_grant_lsu = bus.lsu_valid;
      end
   end

   assign w_accept       = (r_state == S_IDLE) && (w_grant_ifu || w_grant_lsu);
   assign w_owner_rready = r_owner_lsu ? bus.lsu_rready : bus.ifu_rready;

   // Next-state logic; mem_rvalid outside WAIT is deliberately ignored.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept)        w_next_state = S_REQ;  else w_next_state = S_IDLE;
         S_REQ:  if (bus.mem_ready)   w_next_state = S_WAIT; else w_next_state = S_REQ;
         S_WAIT: if (bus.mem_rvalid)  w_next_state = S_RESP; else w_next_state = S_WAIT;
         S_RESP: if (w_owner_rready)  w_next_state = S_IDLE; else w_next_state = S_RESP;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Request latch: IFU fetches go out as plain reads, and reads never carry a byte mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_lsu  <= 1'b0;
         r_owner_lsu <= 1'b0;
         r_addr      <= {ADDR_W{1'b0}};
         r_wen       <= 1'b0;
         r_wdata     <= {DATA_W{1'b0}};
         r_wmask     <= {MASK_W{1'b0}};
      end else if (w_accept) begin
         r_last_lsu  <= w_grant_lsu;
         r_owner_lsu <= w_grant_lsu;
         r_addr      <= w_grant_lsu ? bus.lsu_addr : bus.ifu_addr;
         r_wen       <= w_grant_lsu & bus.lsu_wen;
         r_wdata     <= w_grant_lsu ? bus.lsu_wdata : {DATA_W{1'b0}};
         r_wmask     <= (w_grant_lsu && bus.lsu_wen) ? bus.lsu_wmask : {MASK_W{1'b0}};
      end
   end

   // Response latch; a write acknowledge returns zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= {DATA_W{1'b0}};
      end else if ((r_state == S_WAIT) && bus.mem_rvalid) begin
         r_rdata <= r_wen ? {DATA_W{1'b0}} : bus.mem_rdata;
      end
   end

   assign w_ifu_rvalid  = (r_state == S_RESP) && !r_owner_lsu;
   assign w_lsu_rvalid  = (r_state == S_RESP) &&  r_owner_lsu;

   assign bus.ifu_ready  = (r_state == S_IDLE) && w_grant_ifu;
   assign bus.lsu_ready  = (r_state == S_IDLE) && w_grant_lsu;
   assign bus.ifu_rvalid = w_ifu_rvalid;
   assign bus.lsu_rvalid = w_lsu_rvalid;
   assign bus.ifu_rdata  = w_ifu_rvalid ? r_rdata : {DATA_W{1'b0}};
   assign bus.lsu_rdata  = w_lsu_rvalid ? r_rdata : {DATA_W{1'b0}};

   assign bus.mem_valid  = (r_state == S_REQ);
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wen    = r_wen;
   assign bus.mem_wdata  = r_wdata;
   assign bus.mem_wmask  = r_wmask;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written stall/conflict/reset
// sequences, and random traffic against a transaction-level model.
module tb_mem_arbiter;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int NV     = 12;

   localparam logic        T  = 1'b1;
   localparam logic        F  = 1'b0;
   localparam logic [63:0] Z  = 64'h0;
   localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
   localparam logic [63:0] A1 = 64'h0000_0000_8000_1000;
   localparam logic [63:0] A2 = 64'h0000_0000_8000_2000;
   localparam logic [63:0] D0 = 64'h1122_3344_5566_7788;
   localparam logic [63:0] D1 = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] WD = 64'h0000_0000_0000_AB00;
   localparam logic [7:0]  M0 = 8'h00;
   localparam logic [7:0]  M2 = 8'h02;

   typedef struct {
      logic iv; logic [63:0] ia;
      logic lv; logic [63:0] la; logic lw; logic [63:0] lwd; logic [7:0] lwm;
      logic mr; logic mrv; logic [63:0] mrd; logic rr;
      logic e_ir; logic e_lr; logic e_mv; logic [63:0] e_ma; logic e_mw; logic [7:0] e_mm; logic [63:0] e_mwd;
      logic e_irv; logic [63:0] e_ird; logic e_lrv; logic [63:0] e_lrd;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   proto_errs = 0;
   logic mon_wait;

   vec_t vecs [NV];

   // random-phase model state
   logic        m_busy, m_taken, m_resp, m_own_lsu, m_last_lsu, m_wen;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic [7:0]  m_wmask;
   logic        g_ifu, g_lsu, drop_ifu, drop_lsu;
   int          m_done;

   int   n_acc, last_acc, rv_first;
   logic exp_lsu, hs_prev;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Protocol monitor: memory responses are only legal after an accepted memory request.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mon_wait <= 1'b0;
      end else if (bus.mem_valid && bus.mem_ready) begin
         mon_wait <= 1'b1;
      end else if (bus.mem_rvalid) begin
         if (!mon_wait) begin
            proto_errs <= proto_errs + 1;
            $display("protocol error flagged: mem_rvalid outside WAIT at %0t", $time);
         end
         mon_wait <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.ifu_valid  = 1'b0; bus.ifu_addr  = 64'h0; bus.ifu_rready = 1'b0;
      bus.lsu_valid  = 1'b0; bus.lsu_addr  = 64'h0; bus.lsu_wen    = 1'b0;
      bus.lsu_wdata  = 64'h0; bus.lsu_wmask = 8'h00; bus.lsu_rready = 1'b0;
      bus.mem_ready  = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
   endtask

   task automatic chk_zero(input string tag);
      chk1({tag, " ifu_ready"},  bus.ifu_ready,  1'b0);
      chk1({tag, " lsu_ready"},  bus.lsu_ready,  1'b0);
      chk1({tag, " mem_valid"},  bus.mem_valid,  1'b0);
      chk ({tag, " mem_addr"},   bus.mem_addr,   64'h0);
      chk1({tag, " mem_wen"},    bus.mem_wen,    1'b0);
      chk ({tag, " mem_wdata"},  bus.mem_wdata,  64'h0);
      chk ({tag, " mem_wmask"},  64'(bus.mem_wmask), 64'h0);
      chk1({tag, " ifu_rvalid"}, bus.ifu_rvalid, 1'b0);
      chk ({tag, " ifu_rdata"},  bus.ifu_rdata,  64'h0);
      chk1({tag, " lsu_rvalid"}, bus.lsu_rvalid, 1'b0);
      chk ({tag, " lsu_rdata"},  bus.lsu_rdata,  64'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      bus.ifu_valid  = v.iv;  bus.ifu_addr  = v.ia;
      bus.lsu_valid  = v.lv;  bus.lsu_addr  = v.la;  bus.lsu_wen = v.lw;
      bus.lsu_wdata  = v.lwd; bus.lsu_wmask = v.lwm;
      bus.mem_ready  = v.mr;  bus.mem_rvalid = v.mrv; bus.mem_rdata = v.mrd;
      bus.ifu_rready = v.rr;  bus.lsu_rready = v.rr;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      //            iv ia  lv la  lw lwd lwm mr mrv mrd rr | ir lr mv ma  mw mm  mwd irv ird lrv lrd
      vecs[0]  = '{T, A0, F, Z,  F, Z,  M0, T, F, Z,  T,  T, F, F, Z,  F, M0, Z,  F, Z,  F, Z};
      vecs[1]  = '{F, Z,  F, Z,  F, Z,  M0, T, F, Z,  T,  F, F, T, A0, F, M0, Z,  F, Z,  F, Z};
      vecs[2]  = '{F, Z,  F, Z,  F, Z,  M0, T, T, D0, T,  F, F, F, A0, F, M0, Z,  F, Z,  F, Z};
      vecs[3]  = '{F, Z,  F, Z,  F, Z,  M0, T, F, Z,  T,  F, F, F, A0, F, M0, Z,  T, D0, F, Z};
      vecs[4]  = '{F, Z,  T, A1, T, WD, M2, T, F, Z,  T,  F, T, F, A0, F, M0, Z,  F, Z,  F, Z};
      vecs[5]  = '{F, Z,  F, Z,  F, Z,  M0, T, F, Z,  T,  F, F, T, A1, T, M2, WD, F, Z,  F, Z};
      vecs[6]  = '{F, Z,  F, Z,  F, Z,  M0, T, T, D1, T,  F, F, F, A1, T, M2, WD, F, Z,  F, Z};
      vecs[7]  = '{F, Z,  F, Z,  F, Z,  M0, T, F, Z,  T,  F, F, F, A1, T, M2, WD, F, Z,  T, Z};
      vecs[8]  = '{F, Z,  F, Z,  F, Z,  M0, T, T, D1, T,  F, F, F, A1, T, M2, WD, F, Z,  F, Z};
      vecs[9]  = '{F, Z,  F, Z,  F, Z,  M0, T, F, Z,  T,  F, F, F, A1, T, M2, WD, F, Z,  F, Z};
      vecs[10] = '{T, A2, F, Z,  F, Z,  M0, T, F, Z,  T,  T, F, F, A1, T, M2, WD, F, Z,  F, Z};
      vecs[11] = '{F, Z,  F, Z,  F, Z,  M0, T, F, Z,  T,  F, F, T, A2, F, M0, Z,  F, Z,  F, Z};

      do_reset();

      // Directed table: IFU read, LSU write, spurious mem_rvalid in IDLE
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         apply_vec(vecs[i]);
         #1;
         chk1($sformatf("v%0d ifu_ready", i),  bus.ifu_ready,  vecs[i].e_ir);
         chk1($sformatf("v%0d lsu_ready", i),  bus.lsu_ready,  vecs[i].e_lr);
         chk1($sformatf("v%0d mem_valid", i),  bus.mem_valid,  vecs[i].e_mv);
         chk ($sformatf("v%0d mem_addr", i),   bus.mem_addr,   vecs[i].e_ma);
         chk1($sformatf("v%0d mem_wen", i),    bus.mem_wen,    vecs[i].e_mw);
         chk ($sformatf("v%0d mem_wmask", i),  64'(bus.mem_wmask), 64'(vecs[i].e_mm));
         chk ($sformatf("v%0d mem_wdata", i),  bus.mem_wdata,  vecs[i].e_mwd);
         chk1($sformatf("v%0d ifu_rvalid", i), bus.ifu_rvalid, vecs[i].e_irv);
         chk ($sformatf("v%0d ifu_rdata", i),  bus.ifu_rdata,  vecs[i].e_ird);
         chk1($sformatf("v%0d lsu_rvalid", i), bus.lsu_rvalid, vecs[i].e_lrv);
         chk ($sformatf("v%0d lsu_rdata", i),  bus.lsu_rdata,  vecs[i].e_lrd);
      end

      // Both requesters valid continuously: LSU, IFU, LSU, IFU, one accept every 4 cycles
      do_reset();
      n_acc = 0; last_acc = 0; exp_lsu = 1'b1; hs_prev = 1'b0;
      for (int c = 0; c < 40 && n_acc < 4; c++) begin
         @(negedge clk);
         bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h100;
         bus.lsu_valid = 1'b1; bus.lsu_addr = 64'h200; bus.lsu_wen = 1'b0;
         bus.mem_ready = 1'b1; bus.ifu_rready = 1'b1; bus.lsu_rready = 1'b1;
         bus.mem_rvalid = hs_prev; bus.mem_rdata = 64'(c);
         #1;
         chk1("conflict exclusive", bus.ifu_ready & bus.lsu_ready, 1'b0);
         if (bus.ifu_ready || bus.lsu_ready) begin
            chk1($sformatf("conflict grant %0d lsu", n_acc), bus.lsu_ready, exp_lsu);
            if (n_acc > 0) chk($sformatf("conflict spacing %0d", n_acc), 64'(c - last_acc), 64'd4);
            last_acc = c;
            exp_lsu  = ~exp_lsu;
            n_acc++;
         end
         hs_prev = bus.mem_valid & bus.mem_ready;
      end
      chk("conflict accepts", 64'(n_acc), 64'd4);

      // mem_ready stalled 5 cycles, rready stalled 3 cycles: 8 cycles later than minimum
      do_reset();
      @(negedge clk);
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_3000;
      #1;
      chk1("stall accept", bus.ifu_ready, 1'b1);
      rv_first = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         bus.ifu_valid  = (c == 12);
         bus.ifu_addr   = (c == 12) ? 64'h8000_3008 : 64'h0;
         bus.mem_ready  = (c >= 6);
         bus.mem_rvalid = (c == 7);
         bus.mem_rdata  = (c == 7) ? 64'h0123_4567_89AB_CDEF : 64'h0;
         bus.ifu_rready = (c >= 11);
         #1;
         if (c <= 6) begin
            chk1($sformatf("stall c%0d mem_valid", c), bus.mem_valid, 1'b1);
            chk ($sformatf("stall c%0d mem_addr", c),  bus.mem_addr,  64'h8000_3000);
            chk1($sformatf("stall c%0d mem_wen", c),   bus.mem_wen,   1'b0);
         end
         if (bus.ifu_rvalid && rv_first < 0) rv_first = c;
         if (c >= 8 && c <= 11) chk($sformatf("stall c%0d ifu_rdata", c), bus.ifu_rdata, 64'h0123_4567_89AB_CDEF);
         chk1($sformatf("stall c%0d lsu_rvalid", c), bus.lsu_rvalid, 1'b0);
         if (c == 12) chk1("stall next accept", bus.ifu_ready, 1'b1);
      end
      chk("stall rvalid cycle", 64'(rv_first), 64'd8);

      // Reset while waiting for memory; the late response must vanish
      do_reset();
      @(negedge clk);
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_4000;
      bus.mem_ready = 1'b1; bus.ifu_rready = 1'b1; bus.lsu_rready = 1'b1;
      #1;
      chk1("rstw accept", bus.ifu_ready, 1'b1);
      @(negedge clk);
      bus.ifu_valid = 1'b0;
      #1;
      chk1("rstw mem_valid", bus.mem_valid, 1'b1);
      @(negedge clk);
      #1;
      chk1("rstw in wait", bus.mem_valid, 1'b0);
      rst = 1'b1;
      #1;
      chk_zero("rstw during reset");
      @(negedge clk);
      rst = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h5555_5555_5555_5555;
      #1;
      chk_zero("rstw late rvalid");
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #1;
      chk_zero("rstw after late rvalid");
      @(negedge clk);
      bus.ifu_valid = 1'b1; bus.ifu_addr = 64'h8000_5000;
      #1;
      chk1("rstw new accept", bus.ifu_ready, 1'b1);
      @(negedge clk);
      bus.ifu_valid = 1'b0;
      #1;
      chk ("rstw new mem_addr", bus.mem_addr, 64'h8000_5000);
      @(negedge clk);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h0BAD_F00D_1234_5678;
      #1;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #1;
      chk1("rstw new ifu_rvalid", bus.ifu_rvalid, 1'b1);
      chk ("rstw new ifu_rdata",  bus.ifu_rdata,  64'h0BAD_F00D_1234_5678);
      @(negedge clk);
      #1;
      chk1("rstw new done", bus.ifu_rvalid, 1'b0);

      // Random traffic against a transaction-level model
      do_reset();
      m_busy = 1'b0; m_taken = 1'b0; m_resp = 1'b0; m_last_lsu = 1'b0; m_done = 0;
      drop_ifu = 1'b0; drop_lsu = 1'b0;
      for (int c = 0; c < 4000 && m_done < 60; c++) begin
         @(negedge clk);
         if (drop_ifu) bus.ifu_valid = 1'b0;
         if (drop_lsu) bus.lsu_valid = 1'b0;
         drop_ifu = 1'b0; drop_lsu = 1'b0;
         if (!bus.ifu_valid && $urandom_range(0, 2) == 32'd0) begin
            bus.ifu_valid = 1'b1;
            bus.ifu_addr  = {$urandom(), $urandom()};
         end
         if (!bus.lsu_valid && $urandom_range(0, 2) == 32'd0) begin
            bus.lsu_valid = 1'b1;
            bus.lsu_addr  = {$urandom(), $urandom()};
            bus.lsu_wen   = 1'($urandom_range(0, 1));
            bus.lsu_wdata = {$urandom(), $urandom()};
            bus.lsu_wmask = 8'($urandom_range(0, 255));
         end
         bus.mem_ready  = 1'($urandom_range(0, 1));
         bus.mem_rvalid = m_busy && m_taken && !m_resp && ($urandom_range(0, 2) == 32'd0);
         bus.mem_rdata  = {$urandom(), $urandom()};
         bus.ifu_rready = 1'($urandom_range(0, 1));
         bus.lsu_rready = 1'($urandom_range(0, 1));
         #1;
         g_lsu = bus.lsu_valid && (!bus.ifu_valid || !m_last_lsu);
         g_ifu = bus.ifu_valid && !g_lsu;
         if (!m_busy) begin
            chk1("rnd ifu_ready", bus.ifu_ready, g_ifu);
            chk1("rnd lsu_ready", bus.lsu_ready, g_lsu);
            chk1("rnd idle mem_valid", bus.mem_valid, 1'b0);
            chk1("rnd idle rvalid", bus.ifu_rvalid | bus.lsu_rvalid, 1'b0);
         end else begin
            chk1("rnd busy ready", bus.ifu_ready | bus.lsu_ready, 1'b0);
            chk1("rnd mem_valid", bus.mem_valid, !m_taken);
            if (!m_taken) begin
               chk ("rnd mem_addr",  bus.mem_addr,  m_addr);
               chk1("rnd mem_wen",   bus.mem_wen,   m_wen);
               chk ("rnd mem_wmask", 64'(bus.mem_wmask), 64'(m_wmask));
               chk ("rnd mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk1("rnd ifu_rvalid", bus.ifu_rvalid, m_resp && !m_own_lsu);
            chk1("rnd lsu_rvalid", bus.lsu_rvalid, m_resp &&  m_own_lsu);
            if (m_resp) chk("rnd rdata", m_own_lsu ? bus.lsu_rdata : bus.ifu_rdata, m_rdata);
         end
         if (!m_busy) begin
            if (g_ifu || g_lsu) begin
               m_busy = 1'b1; m_taken = 1'b0; m_resp = 1'b0;
               m_own_lsu = g_lsu; m_last_lsu = g_lsu;
               m_addr  = g_lsu ? bus.lsu_addr : bus.ifu_addr;
               m_wen   = g_lsu && bus.lsu_wen;
               m_wmask = m_wen ? bus.lsu_wmask : 8'h00;
               m_wdata = g_lsu ? bus.lsu_wdata : 64'h0;
               drop_ifu = g_ifu; drop_lsu = g_lsu;
            end
         end else if (!m_taken) begin
            if (bus.mem_ready) m_taken = 1'b1;
         end else if (!m_resp) begin
            if (bus.mem_rvalid) begin
               m_resp  = 1'b1;
               m_rdata = m_wen ? 64'h0 : bus.mem_rdata;
            end
         end else if (m_own_lsu ? bus.lsu_rready : bus.ifu_rready) begin
            m_busy = 1'b0; m_taken = 1'b0; m_resp = 1'b0;
            m_done++;
         end
      end
      chk("rnd completed", 64'(m_done), 64'd60);

      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("protocol errors flagged", 64'(proto_errs), 64'd2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
